// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
// MEM pipeline stage plus MEM/WB register. Runs LDUR/LDURB/STUR against a
// variable-latency data memory over a req/ack handshake, stalls upstream
// while an access is outstanding and produces the WB writeback value.
//
// State table
//   S_IDLE | no access outstanding; non-memory ops pass straight to MEM/WB
//   S_WAIT | dmem_req held, waiting for dmem_ack or timeout
//
// Ports
//   clk, reset              clock (rising edge), async active-low reset
//   MEM_*                   EX/MEM register outputs (control, Rd, ALU, store data)
//   dmem_req/we/addr/wdata/size, dmem_ack/rdata   data memory handshake
//   mem_stall               hold upstream pipe (combinational)
//   WB_RegWrite/Rd/MemToRegOut  MEM/WB register
//   mem_fault               sticky misalign / bad size / timeout flag
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MEM_RegWrite,
    input  logic              MEM_MemWrite,
    input  logic              MEM_read_enable,
    input  logic              MEM_MemToReg,
    input  logic              MEM_NOOP,
    input  logic [3:0]        MEM_xfer_size,
    input  logic [4:0]        MEM_Rd,
    input  logic [DATA_W-1:0] MEM_ALUResult_out,
    input  logic [DATA_W-1:0] MEM_RegB_content,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_size,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              mem_stall,
    output logic              WB_RegWrite,
    output logic [4:0]        WB_Rd,
    output logic [DATA_W-1:0] WB_MemToRegOut,
    output logic              mem_fault
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_memop;
    logic               w_size_ok;
    logic               w_misalign;
    logic               w_bad;
    logic               w_last;
    logic [2:0]         w_align_mask;
    logic [DATA_W-1:0]  w_loadval;
    logic [DATA_W-1:0]  w_result;

    assign w_memop   = !MEM_NOOP && (MEM_MemWrite || MEM_read_enable);
    assign w_size_ok = (MEM_xfer_size == 4'd1) || (MEM_xfer_size == 4'd2) ||
                       (MEM_xfer_size == 4'd4) || (MEM_xfer_size == 4'd8);
    // For legal sizes, size-1 over the low three bits is the alignment mask
    // (8 wraps to 3'b000 - 1 = 3'b111).
    assign w_align_mask = MEM_xfer_size[2:0] - 3'd1;
    assign w_misalign   = (MEM_ALUResult_out[2:0] & w_align_mask) != 3'd0;
    assign w_bad        = !w_size_ok || w_misalign;
    assign w_last       = (r_cnt == CNT_LAST);

    always_comb begin
        w_loadval = dmem_rdata;
        case (dmem_size)
            4'd1:    w_loadval = DATA_W'(dmem_rdata[7:0]);
            4'd2:    w_loadval = DATA_W'(dmem_rdata[15:0]);
            4'd4:    w_loadval = DATA_W'(dmem_rdata[31:0]);
            default: w_loadval = dmem_rdata;
        endcase
    end

    // Stores (MemWrite wins) always write back the ALU result.
    assign w_result = (MEM_MemToReg && !MEM_MemWrite) ? w_loadval : MEM_ALUResult_out;

    // Gated by reset so every output reads 0 while reset is held.
    assign mem_stall = reset && ((r_state == S_IDLE) ? (w_memop && !w_bad)
                                                     : (!dmem_ack && !w_last));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            dmem_size      <= '0;
            WB_RegWrite    <= 1'b0;
            WB_Rd          <= '0;
            WB_MemToRegOut <= '0;
            mem_fault      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_memop) begin
                        WB_RegWrite    <= MEM_RegWrite && !MEM_NOOP;
                        WB_Rd          <= MEM_Rd;
                        WB_MemToRegOut <= MEM_ALUResult_out;
                    end else if (w_bad) begin
                        mem_fault   <= 1'b1;
                        WB_RegWrite <= 1'b0;
                    end else begin
                        dmem_req    <= 1'b1;
                        dmem_we     <= MEM_MemWrite;
                        dmem_addr   <= MEM_ALUResult_out;
                        dmem_wdata  <= MEM_RegB_content;
                        dmem_size   <= MEM_xfer_size;
                        r_cnt       <= '0;
                        WB_RegWrite <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        dmem_req       <= 1'b0;
                        WB_RegWrite    <= MEM_RegWrite;
                        WB_Rd          <= MEM_Rd;
                        WB_MemToRegOut <= w_result;
                        r_state        <= S_IDLE;
                    end else if (w_last) begin
                        dmem_req    <= 1'b0;
                        mem_fault   <= 1'b1;
                        WB_RegWrite <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt       <= r_cnt + 1'b1;
                        WB_RegWrite <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        MEM_RegWrite, MEM_MemWrite, MEM_read_enable, MEM_MemToReg, MEM_NOOP;
    logic [3:0]  MEM_xfer_size;
    logic [4:0]  MEM_Rd;
    logic [63:0] MEM_ALUResult_out, MEM_RegB_content;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_size;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        mem_stall, WB_RegWrite, mem_fault;
    logic [4:0]  WB_Rd;
    logic [63:0] WB_MemToRegOut;

    int errors = 0;
    int checks = 0;
    bit exp_fault = 0;
    bit idle_ack = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.DATA_W(64), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .MEM_RegWrite(MEM_RegWrite), .MEM_MemWrite(MEM_MemWrite),
        .MEM_read_enable(MEM_read_enable), .MEM_MemToReg(MEM_MemToReg),
        .MEM_NOOP(MEM_NOOP), .MEM_xfer_size(MEM_xfer_size), .MEM_Rd(MEM_Rd),
        .MEM_ALUResult_out(MEM_ALUResult_out), .MEM_RegB_content(MEM_RegB_content),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_size(dmem_size), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .WB_RegWrite(WB_RegWrite),
        .WB_Rd(WB_Rd), .WB_MemToRegOut(WB_MemToRegOut), .mem_fault(mem_fault)
    );

    // Runs one instruction through the stage. ack_at = WAIT cycle (1-based)
    // on which dmem_ack is raised; 0 = never.
    task automatic run_op(input string name, input bit rw, input bit wr, input bit rd,
                          input bit m2r, input bit noop, input logic [3:0] size,
                          input logic [4:0] rdn, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] rdata,
                          input int ack_at);
        bit          memop, bad, timeout, exp_rw;
        int          exp_stalls, stalls, cyc;
        bit          done;
        logic [63:0] mask, exp_val;
        memop = !noop && (wr || rd);
        bad = !(size == 1 || size == 2 || size == 4 || size == 8);
        if (!bad) bad = (addr % 64'(size)) != 0;
        timeout = memop && !bad && (ack_at < 1 || ack_at > TIMEOUT);
        if (!memop || bad) exp_stalls = 0;
        else if (timeout)  exp_stalls = TIMEOUT;
        else               exp_stalls = ack_at;
        mask = (size >= 8) ? {64{1'b1}} : ((64'd1 << (8 * size)) - 64'd1);
        exp_val = (memop && !wr && m2r) ? (rdata & mask) : addr;
        if (!memop)             exp_rw = rw && !noop;
        else if (bad || timeout) exp_rw = 0;
        else                    exp_rw = rw;
        if (memop && (bad || timeout)) exp_fault = 1;

        MEM_RegWrite = rw; MEM_MemWrite = wr; MEM_read_enable = rd;
        MEM_MemToReg = m2r; MEM_NOOP = noop; MEM_xfer_size = size; MEM_Rd = rdn;
        MEM_ALUResult_out = addr; MEM_RegB_content = wdata; dmem_rdata = rdata;
        stalls = 0;
        done = 0;
        for (cyc = 0; cyc <= 40 && !done; cyc++) begin
            dmem_ack = (ack_at != 0 && cyc == ack_at) || (cyc == 0 && idle_ack);
            #1;
            if (mem_stall === 1'b1) stalls++;
            else done = 1;
            @(posedge clk); #1;
            if (!done) begin
                checks++;
                if (dmem_req !== 1'b1 || dmem_addr !== addr || dmem_we !== wr ||
                    dmem_size !== size || dmem_wdata !== wdata) begin
                    errors++;
                    $display("FAIL %s req_hold: req=%b addr=%h we=%b size=%0d want req=1 addr=%h we=%b size=%0d",
                             name, dmem_req, dmem_addr, dmem_we, dmem_size, addr, wr, size);
                end
            end
            @(negedge clk);
        end
        dmem_ack = 0;
        idle_ack = 0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s stall_bound: stall still high after 40 cycles", name);
        end
        checks++;
        if (stalls != exp_stalls) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, exp_stalls);
        end
        checks++;
        if (WB_RegWrite !== exp_rw) begin
            errors++;
            $display("FAIL %s wb_regwrite: got %b want %b", name, WB_RegWrite, exp_rw);
        end
        if (exp_rw) begin
            checks++;
            if (WB_Rd !== rdn || WB_MemToRegOut !== exp_val) begin
                errors++;
                $display("FAIL %s wb_value: rd=%0d val=%h want rd=%0d val=%h",
                         name, WB_Rd, WB_MemToRegOut, rdn, exp_val);
            end
        end
        checks++;
        if (mem_fault !== exp_fault || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s fault_req: fault=%b req=%b want fault=%b req=0",
                     name, mem_fault, dmem_req, exp_fault);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (dmem_req !== 0 || dmem_we !== 0 || dmem_addr !== 0 || dmem_wdata !== 0 ||
            dmem_size !== 0 || mem_stall !== 0 || WB_RegWrite !== 0 || WB_Rd !== 0 ||
            WB_MemToRegOut !== 0 || mem_fault !== 0) begin
            errors++;
            $display("FAIL %s outputs_zero: req=%b we=%b addr=%h stall=%b wbrw=%b rd=%0d val=%h fault=%b want all 0",
                     name, dmem_req, dmem_we, dmem_addr, mem_stall, WB_RegWrite, WB_Rd,
                     WB_MemToRegOut, mem_fault);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0;
        exp_fault = 0;
        #1;
        check_all_zero("reset_pulse");
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_reset();
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_add();
        run_op("add", 1, 0, 0, 0, 0, 4'd8, 5'd3, 64'h55, 64'h0, 64'h0, 0);
        run_op("noop", 1, 0, 1, 1, 1, 4'd8, 5'd7, 64'h99, 64'h0, 64'h0, 0);
    endtask

    task automatic test_ldur();
        run_op("ldur", 1, 0, 1, 1, 0, 4'd8, 5'd5, 64'h10, 64'h0,
               64'hDEADBEEF_CAFEF00D, 4);
    endtask

    task automatic test_ldurb();
        run_op("ldurb", 1, 0, 1, 1, 0, 4'd1, 5'd6, 64'h13, 64'h0,
               64'hFFFF_FFFF_FFFF_FFA5, 1);
    endtask

    task automatic test_bad_align();
        run_op("stur_misalign", 0, 1, 0, 0, 0, 4'd8, 5'd0, 64'h0C, 64'h1234, 64'h0, 1);
    endtask

    task automatic test_timeout();
        do_reset();
        run_op("timeout", 1, 0, 1, 1, 0, 4'd8, 5'd9, 64'h20, 64'h0, 64'h77, 0);
        idle_ack = 1;
        run_op("idle_ack", 1, 0, 0, 0, 0, 4'd8, 5'd4, 64'h1234, 64'h0, 64'hBAD, 0);
    endtask

    task automatic test_reset_mid_wait();
        MEM_RegWrite = 1; MEM_MemWrite = 0; MEM_read_enable = 1; MEM_MemToReg = 1;
        MEM_NOOP = 0; MEM_xfer_size = 4'd4; MEM_Rd = 5'd8;
        MEM_ALUResult_out = 64'h40; dmem_ack = 0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        reset = 0;
        exp_fault = 0;
        #1;
        check_all_zero("reset_mid_wait");
        MEM_read_enable = 0; MEM_MemToReg = 0;
        @(negedge clk);
        reset = 1;
        run_op("after_reset", 1, 0, 0, 0, 0, 4'd8, 5'd2, 64'hABCD, 64'h0, 64'h0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int          kind;
            logic [3:0]  sz;
            logic [63:0] a;
            int          ack;
            kind = $urandom_range(0, 2);
            case ($urandom_range(0, 9))
                0:       sz = 4'd3;
                1, 2:    sz = 4'd1;
                3, 4:    sz = 4'd2;
                5, 6:    sz = 4'd4;
                default: sz = 4'd8;
            endcase
            a = {$urandom(), $urandom()};
            if ($urandom_range(0, 9) != 0) a = a & ~64'h7;
            ack = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
            run_op("random", 1'($urandom_range(0, 1)), kind == 1, kind == 2,
                   1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, sz,
                   5'($urandom), a, {$urandom(), $urandom()},
                   {$urandom(), $urandom()}, ack);
        end
    endtask

    initial begin
        reset = 0;
        MEM_RegWrite = 0; MEM_MemWrite = 0; MEM_read_enable = 0; MEM_MemToReg = 0;
        MEM_NOOP = 0; MEM_xfer_size = 0; MEM_Rd = 0; MEM_ALUResult_out = 0;
        MEM_RegB_content = 0; dmem_ack = 0; dmem_rdata = 0;
        @(negedge clk);
        test_reset();
        test_add();
        test_ldur();
        test_ldurb();
        test_bad_align();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
